// File: rtl/calc_key_event_if.sv
// Key/switch input block for the calculator SoC: debounces push-buttons, queues press
// events in a FIFO and exposes them to the HPS over Avalon-MM with a level interrupt.
module calc_key_event_if #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_n,
    input  logic [9:0]  sw,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0]      DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_STATUS   = 2'd0,
        REG_DATA     = 2'd1,
        REG_CTRL     = 2'd2,
        REG_SWITCHES = 2'd3
    } reg_addr_e;

    logic [3:0]       r_key_s1;
    logic [3:0]       r_key_s2;
    logic [9:0]       r_sw_s1;
    logic [9:0]       r_sw_s2;
    logic [3:0]       r_key_stable;
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       r_pending;

    logic [11:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_ovf;
    logic             r_irq_en;
    logic [31:0]      r_readdata;
    logic             r_irq;

    reg_addr_e        w_addr;
    logic [3:0]       w_press;
    logic             w_found;
    logic [1:0]       w_key_idx;
    logic [3:0]       w_clr_mask;
    logic             w_push_req;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_ctrl_wr;
    logic             w_flush;
    logic             w_ovf_clr;
    logic             w_push;
    logic             w_drop;
    logic [11:0]      w_head;
    logic [6:0]       w_count7;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_addr   = reg_addr_e'(avs_address);
    assign w_unused = ^avs_writedata[31:3];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_s1 <= '1;
            r_key_s2 <= '1;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_key_s1 <= key_n;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // A press is the cycle in which a released key's low level has held long enough.
    always_comb begin
        w_press = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_press[i] = r_key_stable[i] & ~r_key_s2[i] & (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_stable <= '1;
            for (int unsigned i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (r_key_s2[i] == r_key_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_key_stable[i] <= r_key_s2[i];
                    r_cnt[i]        <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_found   = 1'b0;
        w_key_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_pending[i] && !w_found) begin
                w_found   = 1'b1;
                w_key_idx = 2'(i);
            end
        end
        w_clr_mask = w_found ? (4'b0001 << w_key_idx) : 4'b0000;
    end

    assign w_push_req = |r_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_press;
        end
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);
    assign w_pop     = avs_read && (w_addr == REG_DATA) && !w_empty;
    assign w_ctrl_wr = avs_write && (w_addr == REG_CTRL);
    assign w_flush   = w_ctrl_wr & avs_writedata[1];
    assign w_ovf_clr = w_ctrl_wr & avs_writedata[2];
    // A same-cycle pop frees the slot, so a full FIFO only drops when nothing leaves.
    assign w_push    = w_push_req && !w_flush && (!w_full || w_pop);
    assign w_drop    = w_push_req && !w_flush && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_sw_s2, w_key_idx};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf    <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_ctrl_wr) begin
                r_irq_en <= avs_writedata[0];
            end
        end
    end

    assign w_head   = r_mem[r_rptr];
    assign w_count7 = 7'(r_count);

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            REG_STATUS:   w_rdata = {r_ovf, 14'b0, r_irq_en, 6'b0, w_full, w_empty, 1'b0, w_count7};
            REG_DATA:     w_rdata = w_empty ? 32'h0 : {1'b1, 13'b0, w_head[11:2], 6'b0, w_head[1:0]};
            REG_CTRL:     w_rdata = {31'b0, r_irq_en};
            REG_SWITCHES: w_rdata = {22'b0, r_sw_s2};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (avs_read) begin
                r_readdata <= w_rdata;
            end
            r_irq <= r_irq_en & (!w_empty | r_ovf);
        end
    end

    assign avs_readdata = r_readdata;
    assign irq          = r_irq;

endmodule

// File: tb/tb_calc_key_event_if.sv
// Bench for calc_key_event_if: table of key-press vectors plus hand-written sequences
// for overflow, interrupt timing, flush and mid-operation reset; reads go through a scoreboard.
module tb_calc_key_event_if;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    always #5 clk = ~clk;

    calc_key_event_if #(
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (4),
        .CNT_W          (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_n        (key_n),
        .sw           (sw),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .irq          (irq)
    );

    typedef struct packed {
        logic [3:0]       keys;
        logic [9:0]       sw;
        logic [7:0]       hold;
        logic [7:0]       nexp;
        logic [31:0]      status;
        logic [3:0][31:0] ev;
    } vec_t;

    vec_t        vt [7];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic        rd_pending = 1'b0;
    logic [31:0] exp_q [$];
    string       name_q [$];
    logic [31:0] sb_e;
    string       sb_n;
    int unsigned lat;
    logic [31:0] ovf_ev [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read data is due one cycle after the strobe; compare it on the following falling edge.
    always @(posedge clk) rd_pending <= avs_read;

    always @(negedge clk) begin
        if (rd_pending) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_underflow: got %h expected no read", avs_readdata);
            end else begin
                sb_e = exp_q.pop_front();
                sb_n = name_q.pop_front();
                chk(sb_n, avs_readdata, sb_e);
            end
        end
    end

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address   = a;
        avs_write     = 1'b1;
        avs_writedata = d;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic press(input logic [3:0] keys, input int unsigned hold);
        @(negedge clk);
        key_n = ~keys;
        repeat (hold) @(negedge clk);
        key_n = 4'hF;
    endtask

    initial begin
        vt[0] = '0; vt[0].keys = 4'b0100; vt[0].sw = 10'h2A5; vt[0].hold = 10; vt[0].nexp = 1;
        vt[0].status = 32'h0000_0001; vt[0].ev[0] = 32'h8002_A502;
        vt[1] = '0; vt[1].keys = 4'b0010; vt[1].sw = 10'h155; vt[1].hold = 2; vt[1].nexp = 0;
        vt[1].status = 32'h0000_0100;
        vt[2] = '0; vt[2].keys = 4'b1001; vt[2].sw = 10'h3FF; vt[2].hold = 10; vt[2].nexp = 2;
        vt[2].status = 32'h0000_0002; vt[2].ev[0] = 32'h8003_FF00; vt[2].ev[1] = 32'h8003_FF03;
        vt[3] = '0; vt[3].keys = 4'b0001; vt[3].sw = 10'h000; vt[3].hold = 6; vt[3].nexp = 1;
        vt[3].status = 32'h0000_0001; vt[3].ev[0] = 32'h8000_0000;
        vt[4] = '0; vt[4].keys = 4'b1111; vt[4].sw = 10'h001; vt[4].hold = 8; vt[4].nexp = 4;
        vt[4].status = 32'h0000_0204; vt[4].ev[0] = 32'h8000_0100; vt[4].ev[1] = 32'h8000_0101;
        vt[4].ev[2] = 32'h8000_0102; vt[4].ev[3] = 32'h8000_0103;
        vt[5] = '0; vt[5].keys = 4'b0100; vt[5].sw = 10'h003; vt[5].hold = 4; vt[5].nexp = 1;
        vt[5].status = 32'h0000_0001; vt[5].ev[0] = 32'h8000_0302;
        vt[6] = '0; vt[6].keys = 4'b0100; vt[6].sw = 10'h000; vt[6].hold = 3; vt[6].nexp = 0;
        vt[6].status = 32'h0000_0100;
        ovf_ev[0] = 32'h8000_0100; ovf_ev[1] = 32'h8000_0200;
        ovf_ev[2] = 32'h8000_0300; ovf_ev[3] = 32'h8000_0400;

        reset = 1'b1; key_n = 4'hF; sw = '0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        cycles(4);
        chk("rst_readdata", avs_readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        rd(2'd0, 32'h0000_0100, "rst_status");
        chk("rst_irq", {31'b0, irq}, 32'h0);
        rd(2'd1, 32'h0000_0000, "rst_data_empty");
        rd(2'd0, 32'h0000_0100, "rst_status2");
        cycles(3);
        chk("readdata_hold", avs_readdata, 32'h0000_0100);

        for (int i = 0; i < 7; i++) begin
            sw = vt[i].sw;
            press(vt[i].keys, int'(vt[i].hold));
            cycles(12);
            rd(2'd0, vt[i].status, $sformatf("vec%0d_status", i));
            for (int j = 0; j < int'(vt[i].nexp); j++) begin
                rd(2'd1, vt[i].ev[j], $sformatf("vec%0d_data%0d", i, j));
            end
            rd(2'd0, 32'h0000_0100, $sformatf("vec%0d_empty", i));
            rd(2'd3, {22'b0, vt[i].sw}, $sformatf("vec%0d_switches", i));
        end

        for (int k = 0; k < 6; k++) begin
            sw = 10'(k + 1);
            press(4'b0001, 6);
            cycles(8);
        end
        rd(2'd0, 32'h8000_0204, "ovf_status");
        chk("ovf_irq_disabled", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h4);
        rd(2'd0, 32'h0000_0204, "ovf_cleared");
        for (int j = 0; j < 4; j++) begin
            rd(2'd1, ovf_ev[j], $sformatf("ovf_data%0d", j));
        end
        rd(2'd0, 32'h0000_0100, "ovf_drained");

        wr(2'd2, 32'h1);
        cycles(2);
        chk("irq_idle", {31'b0, irq}, 32'h0);
        rd(2'd2, 32'h0000_0001, "ctrl_read");
        sw = 10'h0AA;
        @(negedge clk);
        key_n = 4'b1101;
        lat = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (irq) begin
                lat = c;
                break;
            end
        end
        chk("irq_latency", lat, 32'd8);
        cycles(2);
        key_n = 4'hF;
        cycles(10);
        rd(2'd1, 32'h8000_AA01, "irq_data");
        chk("irq_still_high", {31'b0, irq}, 32'h1);
        @(negedge clk);
        chk("irq_fall", {31'b0, irq}, 32'h0);

        press(4'b1000, 6);
        cycles(10);
        rd(2'd0, 32'h0001_0001, "flush_pre");
        wr(2'd2, 32'h3);
        rd(2'd0, 32'h0001_0100, "flush_post");
        cycles(2);
        chk("flush_irq", {31'b0, irq}, 32'h0);

        press(4'b0111, 6);
        cycles(10);
        rd(2'd0, 32'h0001_0003, "rst_mid_pre");
        @(negedge clk);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        rd(2'd0, 32'h0000_0100, "rst_mid_status");
        chk("rst_mid_irq", {31'b0, irq}, 32'h0);
        rd(2'd2, 32'h0000_0000, "rst_mid_ctrl");

        cycles(3);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_leftover: got %0d pending reads expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/calc_key_event_if.md
Name: calc_key_event_if

Overview:
- Input-side companion to the calculator SoC's lamp (seven-segment) output PIO.
- Debounces the four board push-buttons and samples the ten slide switches.
- Turns each debounced key press into an event word and queues it in a small FIFO.
- Presents the FIFO to the HPS as an Avalon-MM responder with fixed read latency, plus a level interrupt.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronized key level must hold before it is accepted (10 ms at 50 MHz).
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- key_n  in  4  raw push-buttons, active-low, asynchronous.
- sw  in  10  raw slide switches, asynchronous.
- avs_address  in  2  word address.
- avs_read  in  1  read strobe, single cycle.
- avs_write  in  1  write strobe, single cycle.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid exactly 1 cycle after avs_read.
- irq  out  1  level interrupt.

Behaviour:
- Reset: avs_readdata=0, irq=0, FIFO empty, overflow=0, irq_en=0.
- Reset: debounced key state = released, debounce counters=0, pending mask=0, synchronizers=released/0.
- Reset mid-operation discards all queued events and pending presses.
- Sync: key_n and sw each pass through a 2-FF synchronizer before any use.
- Debounce, per key: when the synced level equals the stable level, the counter clears.
  - Otherwise the counter increments.
  - At DEBOUNCE_CYCLES-1 the stable level takes the synced level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES causes no stable change.
- Press detect: a stable released->pressed transition sets pending[i]. Release generates nothing.
- Enqueue: each cycle, if pending != 0, take the lowest set index k.
  - Push event {14'b0, sw_sync[9:0], 6'b0, k[1:0]} and clear pending[k]. One push per cycle.
  - Simultaneous presses are therefore queued in ascending index order on consecutive cycles.
  - The switch snapshot is taken in the push cycle.
- Event word layout: [31] valid, [27:18] 0, [17:8] switches, [7:2] 0, [1:0] key index.
- Full: a push while full and not popping in the same cycle is dropped.
  - pending[k] still clears; overflow sets sticky.
- Full with simultaneous push and pop: both occur; count unchanged; no overflow.
- Register map, read (avs_readdata registered, latency 1):
  - 0 STATUS: [31] overflow, [16] irq_en, [9] full, [8] empty, [6:0] count.
  - 1 DATA: read returns the head entry with bit31=1 and pops it in the same cycle as avs_read.
    - When empty it returns 0 and does not pop.
  - 2 CTRL: reads [0] irq_en.
  - 3 SWITCHES: reads {22'b0, sw_sync}.
- Register map, write (takes effect the next cycle):
  - CTRL bit0 -> irq_en.
  - CTRL bit1 = 1 -> flush FIFO. A push in the same cycle as a flush is discarded.
  - CTRL bit2 = 1 -> clear overflow. If an overflow happens in the same cycle, overflow stays set.
  - Writes to addresses 0, 1, 3 are ignored.
- Simultaneous avs_read and avs_write: both honoured; the read returns the pre-write value.
- avs_readdata holds its last value when there is no read.
- irq = irq_en & (!empty | overflow), registered; it deasserts the cycle after the condition clears.
- Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Test Plan (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4):
- Reset release: read STATUS -> 0x0000_0100 (empty); irq=0; read DATA -> 0.
- sw=0x2A5, key_n[2] held low 10 cycles -> single event; read DATA -> 0x8002_A502; next STATUS shows empty.
- key_n[1] low pulse of 2 cycles (shorter than debounce) -> no event; count stays 0.
- key_n[3] and key_n[0] pressed in the same cycle -> DATA reads return key 0 first, then key 3.
- Six presses with no reads -> count=4, full=1, overflow=1. Write CTRL=0x4 -> overflow=0. Four DATA reads return the first four events in order.
- Write CTRL=0x1, press a key -> irq rises after debounce + sync + 2 cycles; DATA read -> irq falls within 2 cycles.
- Assert reset with 3 entries queued -> STATUS reads 0x0000_0100 afterwards.
